// File: rtl/apb_slave_regs.sv
// APB completer with a small 32-bit register file, programmable wait states and
// error signalling. Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write.
module apb_slave_regs #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [31:0]              PADDR,
    input  logic [31:0]              PWDATA,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e               state_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic                 write_q;
    logic [3:0]           wcnt_q;
    logic [31:0]          prdata_q;
    logic                 pready_q;
    logic                 pslverr_q;
    logic [NUM_REGS-1:0]  wr_pulse_q;
    logic [NUM_REGS-1:0]  wr_pulse_d;

    logic                 setup_s;
    logic                 range_ok_s;
    logic                 err_s;
    logic                 complete_s;
    logic                 commit_s;
    logic [IDX_W-1:0]     idx_s;
    logic [31:0]          rdata_s;

    assign setup_s    = PSEL & ~PENABLE;
    assign range_ok_s = (addr_q[31:2] < 30'(NUM_REGS));
    assign idx_s      = addr_q[IDX_W+1:2];
    assign err_s      = (addr_q[1:0] != 2'b00) | ~range_ok_s |
                        (write_q & (addr_q[31:2] == 30'd0));
    assign complete_s = (state_q == ACCESS) & PSEL & (wcnt_q == 4'd0);
    assign commit_s   = complete_s & write_q & ~err_s;

    // Read mux over the flattened register image; errored reads return zero.
    always_comb begin
        rdata_s = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rdata_s |= (idx_s == IDX_W'(i)) ? reg_q[32*i +: 32] : 32'h0;
        end
        if (err_s) begin
            rdata_s = 32'h0;
        end else begin
            rdata_s = rdata_s;
        end
    end

    // One-hot write strobe for the register being committed this edge.
    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse_d[i] = commit_s & (idx_s == IDX_W'(i));
        end
    end

    // Transfer FSM with registered bus outputs and write strobes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            write_q    <= 1'b0;
            wcnt_q     <= 4'd0;
            prdata_q   <= 32'h0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            pready_q   <= 1'b0;
            wr_pulse_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (setup_s) begin
                        addr_q    <= PADDR;
                        wdata_q   <= PWDATA;
                        write_q   <= PWRITE;
                        wcnt_q    <= 4'(WAIT_STATES);
                        pslverr_q <= 1'b0;
                        state_q   <= ACCESS;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        pready_q   <= 1'b1;
                        pslverr_q  <= err_s;
                        wr_pulse_q <= wr_pulse_d;
                        if (!write_q) begin
                            prdata_q <= rdata_s;
                        end
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_q[31:0] = ID_VALUE;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [31:0] r_q;

        // Storage for writable register i, loaded on its commit strobe.
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_q <= 32'h0;
            end else if (wr_pulse_d[i]) begin
                r_q <= wdata_q;
            end
        end

        assign reg_q[32*i +: 32] = r_q;
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: three instances with 0, 3 and 4 wait states
// share one APB bus, each selected by its own PSEL.
module tb_apb_slave_regs;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata   [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [255:0] regq    [3];
    logic [7:0]  wr_pulse [3];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regs #(
            .NUM_REGS   (8),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 4)),
            .ID_VALUE   (32'hA5B0_0001)
        ) u_dut (
            .PCLK    (clk),
            .PRESETn (rst_n),
            .PSEL    (sel[g]),
            .PENABLE (penable),
            .PWRITE  (pwrite),
            .PADDR   (paddr),
            .PWDATA  (pwdata),
            .PRDATA  (prdata[g]),
            .PREADY  (pready[g]),
            .PSLVERR (pslverr[g]),
            .reg_q   (regq[g]),
            .wr_pulse(wr_pulse[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int k, input int i);
        return regq[k][32*i +: 32];
    endfunction

    task automatic bus_idle();
        sel     = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    // Full transfer on instance k; returns at #1 after the completion edge.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rd,
                        output logic err, output logic [7:0] wp, output int waits);
        sel     = 3'b000;
        sel[k]  = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = ~addr;
        pwdata  = ~data;
        waits   = 0;
        @(posedge clk); #1;
        while (!pready[k] && waits < 40) begin
            waits++;
            @(posedge clk); #1;
        end
        check_val("pready_seen", {31'h0, pready[k]}, 32'h1);
        rd  = prdata[k];
        err = pslverr[k];
        wp  = wr_pulse[k];
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [7:0]  wp;
        int          waits;
        logic        seen;

        rst_n = 1'b0; sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check_val("rst_pready",  {31'h0, pready[0]}, 32'h0);
        check_val("rst_pslverr", {31'h0, pslverr[0]}, 32'h0);
        check_val("rst_prdata",  prdata[0], 32'h0);
        check_val("rst_wrpulse", {24'h0, wr_pulse[0]}, 32'h0);
        check_val("rst_reg1",    reg_of(0, 1), 32'h0);
        check_val("rst_reg0_id", reg_of(0, 0), 32'hA5B0_0001);

        // W=0 write then read
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, err, wp, waits);
        check_val("t1_wr_waits", 32'(waits), 32'd0);
        check_val("t1_wr_err",   {31'h0, err}, 32'h0);
        check_val("t1_wr_pulse", {24'h0, wp}, 32'h10);
        check_val("t1_wr_prdata_hold", rd, 32'h0);
        check_val("t1_reg4", reg_of(0, 4), 32'hDEAD_BEEF);
        bus_idle();
        check_val("t1_pulse_drop", {24'h0, wr_pulse[0]}, 32'h0);
        check_val("t1_pready_drop", {31'h0, pready[0]}, 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0, rd, err, wp, waits);
        check_val("t1_rd_waits", 32'(waits), 32'd0);
        check_val("t1_rd_data",  rd, 32'hDEAD_BEEF);
        check_val("t1_rd_err",   {31'h0, err}, 32'h0);
        bus_idle();

        // W=3 read of the ID register
        xfer(1, 1'b0, 32'h00, 32'h0, rd, err, wp, waits);
        check_val("t2_waits", 32'(waits), 32'd3);
        check_val("t2_data",  rd, 32'hA5B0_0001);
        check_val("t2_err",   {31'h0, err}, 32'h0);
        bus_idle();
        check_val("t2_pready_drop", {31'h0, pready[1]}, 32'h0);

        // Error cases on the W=0 instance
        xfer(0, 1'b1, 32'h00, 32'h1234, rd, err, wp, waits);
        check_val("t3_wr0_err",   {31'h0, err}, 32'h1);
        check_val("t3_wr0_pulse", {24'h0, wp}, 32'h0);
        check_val("t3_reg0",      reg_of(0, 0), 32'hA5B0_0001);
        bus_idle();
        xfer(0, 1'b0, 32'h20, 32'h0, rd, err, wp, waits);
        check_val("t3_rd8_err",  {31'h0, err}, 32'h1);
        check_val("t3_rd8_data", rd, 32'h0);
        bus_idle();
        xfer(0, 1'b1, 32'h06, 32'hCAFE_F00D, rd, err, wp, waits);
        check_val("t3_unal_err",   {31'h0, err}, 32'h1);
        check_val("t3_unal_pulse", {24'h0, wp}, 32'h0);
        check_val("t3_reg1_keep",  reg_of(0, 1), 32'h0);
        bus_idle();
        check_val("t3_err_hold", {31'h0, pslverr[0]}, 32'h1);

        // W=4 abort after two access cycles
        sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | pready[2];
        end
        sel = 3'b000; penable = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | pready[2];
        end
        check_val("t4_no_pready", {31'h0, seen}, 32'h0);
        check_val("t4_reg2", reg_of(2, 2), 32'h0);
        xfer(2, 1'b0, 32'h08, 32'h0, rd, err, wp, waits);
        check_val("t4_rd_waits", 32'(waits), 32'd4);
        check_val("t4_rd_data",  rd, 32'h0);
        bus_idle();

        // Reset during the wait states of a W=3 write
        sel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_prdata",  prdata[1], 32'h0);
        check_val("t5_pready",  {31'h0, pready[1]}, 32'h0);
        check_val("t5_reg3",    reg_of(1, 3), 32'h0);
        check_val("t5_pslverr0", {31'h0, pslverr[0]}, 32'h0);
        check_val("t5_reg4_clr", reg_of(0, 4), 32'h0);
        sel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h0C, 32'h0, rd, err, wp, waits);
        check_val("t5_rd_data", rd, 32'h0);
        check_val("t5_rd_err",  {31'h0, err}, 32'h0);
        bus_idle();

        // W=0 back-to-back writes then reads
        for (int i = 1; i <= 3; i++) begin
            xfer(0, 1'b1, 32'(4 * i), 32'(i), rd, err, wp, waits);
            check_val("t6_wr_err",   {31'h0, err}, 32'h0);
            check_val("t6_wr_waits", 32'(waits), 32'd0);
            check_val("t6_wr_pulse", {24'h0, wp}, 32'(1 << i));
        end
        for (int i = 1; i <= 3; i++) begin
            xfer(0, 1'b0, 32'(4 * i), 32'h0, rd, err, wp, waits);
            check_val("t6_rd_data", rd, 32'(i));
            check_val("t6_rd_err",  {31'h0, err}, 32'h0);
        end
        bus_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
